// File: rtl/multi_bot_wb_regs.sv
// Wishbone register block for NUM_BOTS Rojobot channels: motor control, coherent
// BotInfo snapshots, sticky update flags with overrun tracking, and maskable interrupts.
module multi_bot_wb_regs #(
  parameter int          NUM_BOTS    = 2,
  parameter int          ADDR_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CTRL_RST    = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  input  logic [32*NUM_BOTS-1:0]  bot_info_i,
  input  logic [NUM_BOTS-1:0]     bot_upd_i,
  output logic [8*NUM_BOTS-1:0]   mot_ctl_o,
  output logic [NUM_BOTS-1:0]     irq_o,
  output logic                    irq_any_o
);
  localparam int CH_W = ADDR_W - 5;

  // Handshake: a request is cyc&stb seen while neither ack nor err is high; the
  // response (ack for a valid channel, err otherwise) lasts exactly one cycle, and
  // write side effects and read data land on the same edge as the response.
  logic [CH_W-1:0]     ch;
  logic [4:0]          off;
  logic                req;
  logic                hit;
  logic [NUM_BOTS-1:0] sel_ch;
  logic [NUM_BOTS-1:0] wr_ch;
  logic [NUM_BOTS-1:0] ack_wr;
  logic [31:0]         rdata;

  logic [31:0]         snap    [NUM_BOTS];
  logic [7:0]          ovr_cnt [NUM_BOTS];
  logic [7:0]          ctl     [NUM_BOTS];
  logic [NUM_BOTS-1:0] upd_flag;
  logic [NUM_BOTS-1:0] overrun;
  logic [NUM_BOTS-1:0] irq_en;
  logic [NUM_BOTS-1:0] synced;
  logic [NUM_BOTS-1:0] upd_prev;
  logic [NUM_BOTS-1:0] evt;

  assign ch  = wb_adr_i[ADDR_W-1:5];
  assign off = wb_adr_i[4:0];
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  always_comb begin
    sel_ch = '0;
    wr_ch  = '0;
    ack_wr = '0;
    for (int n = 0; n < NUM_BOTS; n++) begin
      sel_ch[n] = (ch == CH_W'(n));
      wr_ch[n]  = req & wb_we_i & wb_sel_i[0] & sel_ch[n];
      ack_wr[n] = wr_ch[n] & (off == 5'h0C) & wb_dat_i[0];
    end
    hit = |sel_ch;
  end

  always_comb begin
    rdata = '0;
    for (int n = 0; n < NUM_BOTS; n++) begin
      if (sel_ch[n]) begin
        case (off)
          5'h00:   rdata = snap[n];
          5'h04:   rdata = {16'h0, ovr_cnt[n], 6'h0, overrun[n], upd_flag[n]};
          5'h08:   rdata = {24'h0, ctl[n]};
          5'h10:   rdata = {31'h0, irq_en[n]};
          default: rdata = '0;
        endcase
      end
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = bot_upd_i;
    end else begin : g_sync
      logic [NUM_BOTS-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= bot_upd_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign evt = synced & ~upd_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (req) begin
        wb_ack_o <= hit;
        wb_err_o <= ~hit;
        wb_dat_o <= hit ? rdata : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_prev <= '0;
      upd_flag <= '0;
      overrun  <= '0;
      irq_en   <= '0;
      irq_o    <= '0;
      for (int n = 0; n < NUM_BOTS; n++) begin
        snap[n]    <= '0;
        ovr_cnt[n] <= '0;
        ctl[n]     <= CTRL_RST;
      end
    end else begin
      upd_prev <= synced;
      for (int n = 0; n < NUM_BOTS; n++) begin
        irq_o[n] <= upd_flag[n] & irq_en[n];
        if (wr_ch[n] && off == 5'h08) ctl[n] <= wb_dat_i[7:0];
        if (wr_ch[n] && off == 5'h10) irq_en[n] <= wb_dat_i[0];
        // A same-edge acknowledge wipes the history, so the event counts as fresh.
        if (evt[n]) begin
          snap[n]     <= bot_info_i[32*n +: 32];
          upd_flag[n] <= 1'b1;
          if (ack_wr[n]) begin
            overrun[n] <= 1'b0;
            ovr_cnt[n] <= '0;
          end else if (upd_flag[n]) begin
            overrun[n] <= 1'b1;
            if (ovr_cnt[n] != 8'hFF) ovr_cnt[n] <= ovr_cnt[n] + 8'd1;
          end
        end else if (ack_wr[n]) begin
          upd_flag[n] <= 1'b0;
          overrun[n]  <= 1'b0;
          ovr_cnt[n]  <= '0;
        end
      end
    end
  end

  always_comb begin
    mot_ctl_o = '0;
    for (int n = 0; n < NUM_BOTS; n++) mot_ctl_o[8*n +: 8] = ctl[n];
  end

  assign irq_any_o = |irq_o;
endmodule

// File: tb/tb_multi_bot_wb_regs.sv
// Bench for multi_bot_wb_regs: reset, capture, overrun, collision, control,
// error/interrupt and back-to-back access scenarios against a read scoreboard.
module tb_multi_bot_wb_regs;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we_r, cyc, stb;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [63:0] bot_info;
  logic [1:0]  bot_upd;
  logic [15:0] mot_ctl;
  logic [1:0]  irq;
  logic        irq_any;

  logic [31:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  multi_bot_wb_regs #(.NUM_BOTS(2), .ADDR_W(8), .SYNC_STAGES(2), .CTRL_RST(8'h00)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we_r),
    .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .bot_info_i(bot_info), .bot_upd_i(bot_upd),
    .mot_ctl_o(mot_ctl), .irq_o(irq), .irq_any_o(irq_any)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  // resp = {responded, ack, err, response still high one cycle later}
  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic [3:0] resp);
    logic got, ak, er;
    got = 1'b0; ak = 1'b0; er = 1'b0; rd = '0;
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we_r = w; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        got = 1'b1; ak = wb_ack_o; er = wb_err_o; rd = wb_dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we_r = 1'b0;
    @(posedge clk); #1;
    resp = {got, ak, er, wb_ack_o | wb_err_o};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch);
    @(posedge clk); #1; bot_upd[ch] = 1'b1;
    @(posedge clk); #1; bot_upd[ch] = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0]  addrs [6];
    logic [31:0] rd, e;
    logic [3:0]  resp;
    addrs = '{8'h08, 8'h04, 8'h00, 8'h28, 8'h24, 8'h20};
    reset = 1'b1;
    idle(3);
    checks++;
    if ({wb_ack_o, wb_err_o, wb_dat_o, mot_ctl, irq, irq_any} !== '0)
      $display("FAIL reset_outputs: ack=%b err=%b dat=%h mot=%h irq=%b any=%b, want all 0",
               wb_ack_o, wb_err_o, wb_dat_o, mot_ctl, irq, irq_any);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h0);
      bus(addrs[i], 1'b0, 32'h0, 4'hF, rd, resp);
      e = exp_q.pop_front();
      checks++;
      if ({resp, rd} !== {4'b1100, e})
        $display("FAIL reset_read %h: resp=%b data=%h, want resp=1100 data=%h", addrs[i], resp, rd, e);
      else passes++;
    end
  endtask

  task automatic test_capture;
    logic [7:0]  addrs [3];
    logic [31:0] rd, e;
    logic [3:0]  resp;
    addrs = '{8'h24, 8'h20, 8'h20};
    bot_info[63:32] = 32'h1234_5678;
    pulse(1);
    idle(4);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      bus(addrs[i], 1'b0, 32'h0, 4'hF, rd, resp);
      e = exp_q.pop_front();
      checks++;
      if ({resp, rd} !== {4'b1100, e})
        $display("FAIL capture_read%0d %h: resp=%b data=%h, want resp=1100 data=%h", i, addrs[i], resp, rd, e);
      else passes++;
      if (i == 1) begin
        bot_info[63:32] = 32'hDEAD_BEEF;
        idle(4);
      end
    end
  endtask

  task automatic test_overrun;
    logic [31:0] rd, e;
    logic [3:0]  resp;
    @(posedge clk); #1; bot_upd[0] = 1'b1;
    idle(10);
    bot_upd[0] = 1'b0;
    idle(4);
    exp_q.push_back(32'h0000_0001);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL level_single_event: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    for (int i = 0; i < 5; i++) pulse(0);
    idle(4);
    exp_q.push_back(32'h0000_0503);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL overrun_count5: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    for (int i = 0; i < 295; i++) pulse(0);
    idle(4);
    exp_q.push_back(32'h0000_FF03);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL overrun_saturate: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    bus(8'h0C, 1'b1, 32'h1, 4'b1110, rd, resp);
    exp_q.push_back(32'h0000_FF03);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL ack_needs_sel0: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    bus(8'h0C, 1'b1, 32'h1, 4'b0001, rd, resp);
    exp_q.push_back(32'h0);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL ack_clears: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
  endtask

  task automatic test_collision;
    logic [31:0] rd, e;
    logic [3:0]  resp;
    pulse(0);
    idle(2);
    pulse(0);
    idle(4);
    exp_q.push_back(32'h0000_0103);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL collision_setup: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    // Pulse sampled at edge 1, event at edge 3; the write below is acked at edge 3.
    bot_info[31:0] = 32'hCAFE_F00D;
    @(posedge clk); #1; bot_upd[0] = 1'b1;
    @(posedge clk); #1; bot_upd[0] = 1'b0;
    bus(8'h0C, 1'b1, 32'h1, 4'b0001, rd, resp);
    idle(2);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'hCAFE_F00D);
    bus(8'h04, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL collision_status: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
    bus(8'h00, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL collision_snapshot: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
  endtask

  task automatic test_control;
    logic [31:0] rd, e;
    logic [3:0]  resp;
    bus(8'h28, 1'b1, 32'hAABB_CC5A, 4'b0001, rd, resp);
    checks++;
    if ({resp, mot_ctl} !== {4'b1100, 16'h5A00})
      $display("FAIL ctrl_write: resp=%b mot=%h, want resp=1100 mot=5a00", resp, mot_ctl);
    else passes++;
    bus(8'h28, 1'b1, 32'h1122_3344, 4'b1110, rd, resp);
    checks++;
    if (mot_ctl !== 16'h5A00) $display("FAIL ctrl_sel_masked: mot=%h, want 5a00", mot_ctl);
    else passes++;
    exp_q.push_back(32'h0000_005A);
    bus(8'h28, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd} !== {4'b1100, e}) $display("FAIL ctrl_read: resp=%b data=%h, want data=%h", resp, rd, e);
    else passes++;
  endtask

  task automatic test_error;
    logic [7:0]  addrs [3];
    logic [31:0] rd, e;
    logic [3:0]  resp;
    addrs = '{8'h34, 8'h2C, 8'h0C};
    bus(8'h48, 1'b1, 32'hFF, 4'hF, rd, resp);
    checks++;
    if ({resp, mot_ctl} !== {4'b1010, 16'h5A00})
      $display("FAIL err_write: resp=%b mot=%h, want resp=1010 mot=5a00", resp, mot_ctl);
    else passes++;
    bus(8'h40, 1'b0, 32'h0, 4'hF, rd, resp);
    checks++;
    if ({resp, rd} !== {4'b1010, 32'h0}) $display("FAIL err_read: resp=%b data=%h, want resp=1010 data=0", resp, rd);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      bus(addrs[i], 1'b0, 32'h0, 4'hF, rd, resp);
      e = exp_q.pop_front();
      checks++;
      if ({resp, rd} !== {4'b1100, e})
        $display("FAIL zero_read %h: resp=%b data=%h, want resp=1100 data=%h", addrs[i], resp, rd, e);
      else passes++;
    end
  endtask

  task automatic test_irq;
    logic [31:0] rd, e;
    logic [3:0]  resp;
    bus(8'h2C, 1'b1, 32'h1, 4'b0001, rd, resp);
    bus(8'h30, 1'b1, 32'h1, 4'b0001, rd, resp);
    exp_q.push_back(32'h1);
    bus(8'h30, 1'b0, 32'h0, 4'hF, rd, resp);
    e = exp_q.pop_front();
    checks++;
    if ({resp, rd, irq} !== {4'b1100, e, 2'b00})
      $display("FAIL irq_en_read: resp=%b data=%h irq=%b, want data=%h irq=00", resp, rd, irq, e);
    else passes++;
    @(posedge clk); #1; bot_upd[1] = 1'b1;
    @(posedge clk); #1; bot_upd[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (irq !== 2'b00) $display("FAIL irq_latency_early: irq=%b, want 00", irq);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({irq, irq_any} !== {2'b10, 1'b1}) $display("FAIL irq_raise: irq=%b any=%b, want 10/1", irq, irq_any);
    else passes++;
    bus(8'h2C, 1'b1, 32'h1, 4'b0001, rd, resp);
    checks++;
    if ({irq, irq_any} !== 3'b000) $display("FAIL irq_clear: irq=%b any=%b, want 00/0", irq, irq_any);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int acks, errs, bad;
    acks = 0; errs = 0; bad = 0;
    @(posedge clk); #1;
    adr = 8'h28; we_r = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        acks++;
        if (wb_dat_o !== 32'h0000_005A) bad++;
      end
      if (wb_err_o) errs++;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (acks !== 4 || errs !== 0 || bad !== 0)
      $display("FAIL back_to_back: acks=%0d errs=%0d bad_data=%0d, want 4/0/0", acks, errs, bad);
    else passes++;
  endtask

  initial begin
    reset = 1'b1; adr = '0; wdat = '0; sel = '0; we_r = 1'b0; cyc = 1'b0; stb = 1'b0;
    bot_info = '0; bot_upd = '0;
    test_reset;
    test_capture;
    test_overrun;
    test_collision;
    test_control;
    test_error;
    test_irq;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multi_bot_wb_regs.md
Name: multi_bot_wb_regs

Overview:
- Parametrised Wishbone register block serving NUM_BOTS Rojobot channels behind a single slave port.
- Per channel:
  - motor-control register;
  - BotInfo snapshot, captured coherently on each update pulse;
  - sticky update flag with write-to-acknowledge;
  - overrun detection with a saturating overrun counter;
  - maskable interrupt.
- Sits between the Wishbone interconnect and the bot instances.

Parameters:
- NUM_BOTS, 2: number of bot channels, 1..8.
- ADDR_W, 8: Wishbone address bits decoded.
- SYNC_STAGES, 2: synchroniser flops on bot_upd_i. 0 = bypass, for sources already in the clk domain.
- CTRL_RST, 8'h00: reset value of every motor-control register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_adr_i  in  ADDR_W  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, valid with ack
- wb_ack_o  out  1  access acknowledge
- wb_err_o  out  1  error acknowledge, for a channel index out of range
- bot_info_i  in  32*NUM_BOTS  per channel {LocX,LocY,Sensors,BotInfo}; channel n occupies [32n+31:32n]
- bot_upd_i  in  NUM_BOTS  per-channel update level/pulse from the bot
- mot_ctl_o  out  8*NUM_BOTS  per-channel motor control
- irq_o  out  NUM_BOTS  per-channel interrupt
- irq_any_o  out  1  OR of irq_o

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is synchronous and active-high.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - mot_ctl_o = CTRL_RST replicated per channel.
  - Snapshots=0, flags=0, overrun=0, counters=0, irq_en=0, irq_o=0.
  - Synchroniser and edge-detect flops cleared.
  - Reset asserted mid-access drops ack the same edge; the access is lost.
- Decode:
  - ch = wb_adr_i[ADDR_W-1:5]; off = wb_adr_i[4:0].
  - ch >= NUM_BOTS: respond with wb_err_o instead of wb_ack_o, read data 0, no state change.
- Register map per channel, at base ch*0x20:
  - 0x00 INFO, RO: snapshot.
  - 0x04 STATUS, RO: [0]=upd_flag, [1]=overrun, [15:8]=ovr_cnt, rest 0.
  - 0x08 CTRL, RW: [7:0] motor control; write honours wb_sel_i[0] only.
  - 0x0C ACK, WO: writing [0]=1 with sel[0] clears upd_flag, overrun and ovr_cnt. Reads as 0.
  - 0x10 IRQ_EN, RW: bit [0].
  - Other offsets: read 0, writes ignored, normal ack.
- Handshake:
  - Ack/err is asserted on the edge after cyc&stb is seen high with ack/err low, for exactly one cycle.
  - Back-to-back strobes therefore get ack every second cycle.
  - Write side effects and wb_dat_o update take effect on that same edge.
  - wb_dat_o holds its value between accesses.
- Update path, per channel:
  - bot_upd_i passes through SYNC_STAGES flops, then a registered edge detect.
  - Event = synced high AND previous synced low.
  - On an event edge: snapshot <= bot_info_i slice; upd_flag <= 1.
  - If upd_flag was already 1 (unacknowledged): overrun <= 1 and ovr_cnt increments, saturating at 8'hFF.
  - Latency: upd_flag is visible SYNC_STAGES+1 clocks after bot_upd_i is first sampled high.
  - A bot_upd_i level held high produces a single event.
- Simultaneous ACK write and event on the same channel, same edge:
  - Event wins: upd_flag=1 and the new snapshot is taken.
  - overrun=0, ovr_cnt=0: the ack clears the history and this event is not an overrun.
- Interrupts:
  - irq_o[n] = upd_flag[n] & irq_en[n], registered; it follows the flag by one cycle.
  - irq_any_o = OR of irq_o, combinational from registered bits.
- Independence: all channels are independent; events on several channels on the same edge are all captured.

Test Plan:
- Reset: hold reset 3 cycles with CTRL_RST=8'h00. Read 0x08, 0x04, 0x00 of ch0/ch1 -> all 0; irq_o=0; ack exactly 1 cycle per access.
- Capture: bot_info_i ch1 = 32'h1234_5678, pulse bot_upd_i[1] high 1 cycle, SYNC_STAGES=2 -> STATUS(0x24)[0]=1 on cycle 3. Read 0x20 -> 32'h12345678. Change input to 32'hDEADBEEF with no pulse -> read still 32'h12345678.
- Overrun: 300 update pulses on ch0 with no ack -> STATUS[1]=1, [15:8]=8'hFF. Write 0x0C=1 -> STATUS reads 0.
- Collision: schedule the ACK write edge to coincide with a ch0 event edge, with ch0 flag previously set -> STATUS = 32'h0000_0001.
- Control: write 0x28 data 32'hAABBCC5A with sel=4'b0001 -> mot_ctl_o[15:8]=8'h5A. Write with sel=4'b1110 -> unchanged.
- Error/IRQ: with NUM_BOTS=2, access address 0x40 -> wb_err_o=1, wb_ack_o=0, data 0. Set IRQ_EN ch1=1, then update ch1 -> irq_o=2'b10, irq_any_o=1. Ack ch1 -> both 0 the next cycle.
